// File: rtl/condexec_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes,
// flag bit positions and the default IT-block depth.
package condexec_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int ITMAX_DEFAULT = 4;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator; NV is forced to fail so an else-slot
// of an AL block never executes.
module cond_eval
    import condexec_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v, ge;

    assign n  = flags_i[FLAG_N];
    assign z  = flags_i[FLAG_Z];
    assign c  = flags_i[FLAG_C];
    assign v  = flags_i[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            EQ:      pass_o = z;
            NE:      pass_o = ~z;
            CS:      pass_o = c;
            CC:      pass_o = ~c;
            MI:      pass_o = n;
            PL:      pass_o = ~n;
            VS:      pass_o = v;
            VC:      pass_o = ~v;
            HI:      pass_o = c & ~z;
            LS:      pass_o = ~c | z;
            GE:      pass_o = ge;
            LT:      pass_o = ~ge;
            GT:      pass_o = ~z & ge;
            LE:      pass_o = z | ~ge;
            AL:      pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/condexec_unit.sv
// Conditional-execution unit with per-bank flags and Thumb-style IT blocks.
// IT state per bank:  state  | meaning
//                     IDLE   | rem_q == 0, instructions use their own Cond
//                     ACTIVE | rem_q != 0, condition comes from stored ItCond/ItPat
module condexec_unit
    import condexec_pkg::*;
#(
    parameter int NBANKS = 2,
    parameter int ITMAX  = ITMAX_DEFAULT
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           valid,
    input  logic                                           flush,
    input  logic [((NBANKS > 1) ? $clog2(NBANKS) : 1)-1:0] bank,
    input  logic [3:0]                                     Cond,
    input  logic [3:0]                                     ALUFlags,
    input  logic [1:0]                                     FlagW,
    input  logic                                           PCS,
    input  logic                                           RegW,
    input  logic                                           MemW,
    input  logic                                           ItStart,
    input  logic [3:0]                                     ItCond,
    input  logic [$clog2(ITMAX+1)-1:0]                     ItLen,
    input  logic [ITMAX-1:0]                               ItPat,
    output logic                                           PCSrc,
    output logic                                           RegWrite,
    output logic                                           MemWrite,
    output logic                                           CondEx,
    output logic                                           ItActive,
    output logic [$clog2(ITMAX+1)-1:0]                     ItRemain,
    output logic                                           ItErr
);

    localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int LW = $clog2(ITMAX + 1);
    localparam int SW = (ITMAX > 1) ? $clog2(ITMAX) : 1;

    logic [3:0]       flags_q [NBANKS];
    logic [3:0]       flags_d [NBANKS];
    logic [LW-1:0]    rem_q   [NBANKS];
    logic [LW-1:0]    rem_d   [NBANKS];
    logic [SW-1:0]    slot_q  [NBANKS];
    logic [SW-1:0]    slot_d  [NBANKS];
    logic [3:0]       itc_q   [NBANKS];
    logic [3:0]       itc_d   [NBANKS];
    logic [ITMAX-1:0] itp_q   [NBANKS];
    logic [ITMAX-1:0] itp_d   [NBANKS];

    logic [3:0]       flags_sel;
    logic [LW-1:0]    rem_sel;
    logic [SW-1:0]    slot_sel;
    logic [3:0]       itc_sel;
    logic [ITMAX-1:0] itp_sel;

    logic       in_it, then_slot, pass, it_len_ok, it_open, live, go;
    logic [3:0] eff_cond;

    always_comb begin
        flags_sel = '0;
        rem_sel   = '0;
        slot_sel  = '0;
        itc_sel   = '0;
        itp_sel   = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (bank == BW'(b)) begin
                flags_sel = flags_q[b];
                rem_sel   = rem_q[b];
                slot_sel  = slot_q[b];
                itc_sel   = itc_q[b];
                itp_sel   = itp_q[b];
            end
        end
    end

    // Else-slots flip the condition LSB; AL therefore becomes NV and fails.
    assign in_it     = (rem_sel != '0);
    assign then_slot = itp_sel[slot_sel];
    assign eff_cond  = in_it ? (then_slot ? itc_sel : {itc_sel[3:1], ~itc_sel[0]}) : Cond;

    cond_eval u_cond_eval (
        .cond_i  (eff_cond),
        .flags_i (flags_sel),
        .pass_o  (pass)
    );

    // An IT instruction opening a block executes but writes nothing.
    assign it_len_ok = (ItLen != '0) && (ItLen <= LW'(ITMAX));
    assign it_open   = ItStart && !in_it;
    assign live      = valid && !flush;
    assign CondEx    = !flush && (it_open ? it_len_ok : pass);
    assign go        = live && CondEx && !it_open;

    assign PCSrc    = go && PCS;
    assign RegWrite = go && RegW;
    assign MemWrite = go && MemW;
    assign ItActive = in_it;
    assign ItRemain = rem_sel;
    assign ItErr    = live && ItStart && (in_it || !it_len_ok);

    always_comb begin
        flags_d = flags_q;
        rem_d   = rem_q;
        slot_d  = slot_q;
        itc_d   = itc_q;
        itp_d   = itp_q;
        for (int b = 0; b < NBANKS; b++) begin
            if (flush) begin
                rem_d[b]  = '0;
                slot_d[b] = '0;
            end else if (valid && bank == BW'(b)) begin
                if (go && FlagW[1]) begin
                    flags_d[b][FLAG_N] = ALUFlags[FLAG_N];
                    flags_d[b][FLAG_Z] = ALUFlags[FLAG_Z];
                end
                if (go && FlagW[0]) begin
                    flags_d[b][FLAG_C] = ALUFlags[FLAG_C];
                    flags_d[b][FLAG_V] = ALUFlags[FLAG_V];
                end
                if (it_open && it_len_ok) begin
                    rem_d[b]  = ItLen;
                    slot_d[b] = '0;
                    itc_d[b]  = ItCond;
                    itp_d[b]  = ItPat;
                end else if (in_it) begin
                    // Slots are consumed whether or not the instruction executes.
                    if (PCSrc || rem_q[b] == LW'(1)) begin
                        rem_d[b]  = '0;
                        slot_d[b] = '0;
                    end else begin
                        rem_d[b]  = rem_q[b] - LW'(1);
                        slot_d[b] = slot_q[b] + SW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NBANKS; b++) begin
                flags_q[b] <= '0;
                rem_q[b]   <= '0;
                slot_q[b]  <= '0;
                itc_q[b]   <= '0;
                itp_q[b]   <= '0;
            end
        end else begin
            flags_q <= flags_d;
            rem_q   <= rem_d;
            slot_q  <= slot_d;
            itc_q   <= itc_d;
            itp_q   <= itp_d;
        end
    end

endmodule

// File: tb/tb_condexec_unit.sv
// Scoreboard bench for condexec_unit: a reference model predicts each cycle's
// outputs, scenario tasks add fixed-value checks on the recorded observations.
module tb_condexec_unit;

    localparam int NB = 2;
    localparam int IM = 4;

    logic       clk = 1'b0;
    logic       reset, valid, flush;
    logic [0:0] bank;
    logic [3:0] Cond, ALUFlags, ItCond, ItPat;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, ItStart;
    logic [2:0] ItLen, ItRemain;
    logic       PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItErr;

    condexec_unit #(.NBANKS(NB), .ITMAX(IM)) dut (
        .clk(clk), .reset(reset), .valid(valid), .flush(flush), .bank(bank),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .ItStart(ItStart), .ItCond(ItCond), .ItLen(ItLen), .ItPat(ItPat),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .ItActive(ItActive), .ItRemain(ItRemain), .ItErr(ItErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid, flush;
        logic [0:0] bank;
        logic [3:0] cond, aluf;
        logic [1:0] flagw;
        logic       pcs, regw, memw, its;
        logic [3:0] itc;
        logic [2:0] itl;
        logic [3:0] itp;
    } stim_t;

    // Observation layout: {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain[2:0], ItErr}
    logic [8:0] exp_q [$];
    logic [8:0] log_q [$];
    logic [8:0] e, obs;
    stim_t      sq [$];
    int         checks = 0;
    int         failures = 0;

    logic [3:0] m_flags [NB];
    int         m_rem   [NB];
    int         m_slot  [NB];
    logic [3:0] m_cond  [NB];
    logic [3:0] m_pat   [NB];

    function automatic bit m_eval(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cf = f[1], v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s = '{valid: 1'b0, flush: 1'b0, bank: 1'b0, cond: 4'h0, aluf: 4'h0,
                     flagw: 2'b00, pcs: 1'b0, regw: 1'b0, memw: 1'b0, its: 1'b0,
                     itc: 4'h0, itl: 3'd0, itp: 4'h0};
        return s;
    endfunction

    function automatic stim_t ins(input logic [0:0] b, input logic [3:0] c);
        stim_t s = idle();
        s.valid = 1'b1; s.bank = b; s.cond = c; s.regw = 1'b1;
        return s;
    endfunction

    function automatic stim_t wflags(input logic [0:0] b, input logic [3:0] f, input logic [1:0] w);
        stim_t s = ins(b, 4'hE);
        s.aluf = f; s.flagw = w;
        return s;
    endfunction

    function automatic stim_t itst(input logic [0:0] b, input logic [3:0] c, input logic [2:0] l,
                                   input logic [3:0] p);
        stim_t s = ins(b, 4'hE);
        s.its = 1'b1; s.itc = c; s.itl = l; s.itp = p; s.memw = 1'b1;
        s.flagw = 2'b11; s.aluf = 4'hF;
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_flags[k] = 4'h0; m_rem[k] = 0; m_slot[k] = 0; m_cond[k] = 4'h0; m_pat[k] = 4'h0;
        end
    endtask

    task automatic do_reset();
        stim_t s = idle();
        @(negedge clk);
        reset = 1'b1;
        valid = s.valid; flush = s.flush; bank = s.bank; Cond = s.cond; ALUFlags = s.aluf;
        FlagW = s.flagw; PCS = s.pcs; RegW = s.regw; MemW = s.memw; ItStart = s.its;
        ItCond = s.itc; ItLen = s.itl; ItPat = s.itp;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drive one cycle, push the model's prediction, then advance the model.
    task automatic issue(input stim_t s);
        int b;
        bit act, lenok, itopen, live, cx, go;
        logic [3:0] eff;
        @(negedge clk);
        valid = s.valid; flush = s.flush; bank = s.bank; Cond = s.cond; ALUFlags = s.aluf;
        FlagW = s.flagw; PCS = s.pcs; RegW = s.regw; MemW = s.memw; ItStart = s.its;
        ItCond = s.itc; ItLen = s.itl; ItPat = s.itp;
        b      = int'(s.bank);
        act    = (m_rem[b] != 0);
        eff    = !act ? s.cond : (m_pat[b][m_slot[b]] ? m_cond[b] : (m_cond[b] ^ 4'b0001));
        lenok  = (s.itl >= 3'd1) && (int'(s.itl) <= IM);
        itopen = s.its && !act;
        live   = s.valid && !s.flush;
        cx     = !s.flush && (itopen ? lenok : m_eval(eff, m_flags[b]));
        go     = live && cx && !itopen;
        exp_q.push_back({go && s.pcs, go && s.regw, go && s.memw, cx, act, 3'(m_rem[b]),
                         live && s.its && (act || !lenok)});
        if (s.flush) begin
            for (int k = 0; k < NB; k++) begin
                m_rem[k] = 0; m_slot[k] = 0;
            end
        end else if (live) begin
            if (go && s.flagw[1]) m_flags[b][3:2] = s.aluf[3:2];
            if (go && s.flagw[0]) m_flags[b][1:0] = s.aluf[1:0];
            if (itopen && lenok) begin
                m_rem[b] = int'(s.itl); m_slot[b] = 0; m_cond[b] = s.itc; m_pat[b] = s.itp;
            end else if (act) begin
                if (go && s.pcs) m_rem[b] = 0;
                else begin
                    m_rem[b]--; m_slot[b]++;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        sq = {}; log_q = {};
        sq.push_back(idle());
        sq.push_back(ins(0, 4'h0));
        foreach (sq[i]) begin
            issue(sq[i]); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            log_q.push_back(obs); checks++;
            if (obs !== e) begin failures++; $display("FAIL reset[%0d] got=%b want=%b", i, obs, e); end
        end
        checks++;
        if (log_q[0] !== 9'b0) begin failures++; $display("FAIL reset_outputs got=%b want=%b", log_q[0], 9'b0); end
        checks++;
        if (log_q[1][5] !== 1'b0) begin failures++; $display("FAIL reset_eq_z0 got=%b want=0", log_q[1][5]); end
    endtask

    task automatic test_flags();
        sq = {}; log_q = {};
        sq.push_back(ins(0, 4'h0));
        sq.push_back(wflags(0, 4'b0100, 2'b10));
        sq.push_back(ins(0, 4'h0));
        sq.push_back(wflags(0, 4'b0010, 2'b01));
        sq.push_back(ins(0, 4'h2));
        sq.push_back(ins(0, 4'h8));
        for (int k = 0; k < 16; k++) begin
            sq.push_back(wflags(0, 4'($urandom), 2'b11));
            sq.push_back(ins(0, 4'(k)));
        end
        foreach (sq[i]) begin
            issue(sq[i]); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            log_q.push_back(obs); checks++;
            if (obs !== e) begin failures++; $display("FAIL flags[%0d] got=%b want=%b", i, obs, e); end
        end
        checks++;
        if (log_q[1][7] !== 1'b1) begin failures++; $display("FAIL flags_al_regwrite got=%b want=1", log_q[1][7]); end
        checks++;
        if (log_q[2][5] !== 1'b1) begin failures++; $display("FAIL flags_eq_after_z got=%b want=1", log_q[2][5]); end
        checks++;
        if (log_q[4][5] !== 1'b1) begin failures++; $display("FAIL flags_cs got=%b want=1", log_q[4][5]); end
        checks++;
        if (log_q[5][5] !== 1'b0) begin failures++; $display("FAIL flags_hi_z1 got=%b want=0", log_q[5][5]); end
    endtask

    task automatic test_it_basic();
        sq = {}; log_q = {};
        sq.push_back(wflags(0, 4'b0100, 2'b11));
        sq.push_back(itst(0, 4'h0, 3'd3, 4'b0101));
        sq.push_back(ins(0, 4'hF));
        sq.push_back(ins(0, 4'hF));
        sq.push_back(ins(0, 4'hF));
        sq.push_back(ins(0, 4'hF));
        foreach (sq[i]) begin
            issue(sq[i]); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            log_q.push_back(obs); checks++;
            if (obs !== e) begin failures++; $display("FAIL it_basic[%0d] got=%b want=%b", i, obs, e); end
        end
        checks++;
        if (log_q[1][8:5] !== 4'b0001) begin failures++; $display("FAIL it_instr_nowrite got=%b want=0001", log_q[1][8:5]); end
        checks++;
        if (log_q[2][5:1] !== 5'b11011) begin failures++; $display("FAIL it_slot0 got=%b want=11011", log_q[2][5:1]); end
        checks++;
        if (log_q[3][5:1] !== 5'b01010) begin failures++; $display("FAIL it_slot1 got=%b want=01010", log_q[3][5:1]); end
        checks++;
        if (log_q[4][5:1] !== 5'b11001) begin failures++; $display("FAIL it_slot2 got=%b want=11001", log_q[4][5:1]); end
        checks++;
        if (log_q[5][5:1] !== 5'b00000) begin failures++; $display("FAIL it_done got=%b want=00000", log_q[5][5:1]); end
    endtask

    task automatic test_it_flagwrite();
        sq = {}; log_q = {};
        sq.push_back(wflags(0, 4'b0100, 2'b11));
        sq.push_back(itst(0, 4'h0, 3'd2, 4'b0011));
        sq.push_back(wflags(0, 4'b0000, 2'b10));
        sq.push_back(ins(0, 4'hE));
        foreach (sq[i]) begin
            issue(sq[i]); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            log_q.push_back(obs); checks++;
            if (obs !== e) begin failures++; $display("FAIL it_flagw[%0d] got=%b want=%b", i, obs, e); end
        end
        checks++;
        if (log_q[2][5] !== 1'b1) begin failures++; $display("FAIL it_flagw_slot0 got=%b want=1", log_q[2][5]); end
        checks++;
        if (log_q[3][5] !== 1'b0) begin failures++; $display("FAIL it_flagw_slot1 got=%b want=0", log_q[3][5]); end
    endtask

    task automatic test_banks();
        sq = {}; log_q = {};
        sq.push_back(wflags(1, 4'b0000, 2'b11));
        sq.push_back(itst(0, 4'hE, 3'd2, 4'b0011));
        sq.push_back(ins(1, 4'h0));
        sq.push_back(ins(1, 4'h1));
        sq.push_back(ins(0, 4'hF));
        sq.push_back(ins(0, 4'hF));
        sq.push_back(idle());
        foreach (sq[i]) begin
            issue(sq[i]); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            log_q.push_back(obs); checks++;
            if (obs !== e) begin failures++; $display("FAIL banks[%0d] got=%b want=%b", i, obs, e); end
        end
        checks++;
        if (log_q[2][5:4] !== 2'b00) begin failures++; $display("FAIL bank1_own_cond got=%b want=00", log_q[2][5:4]); end
        checks++;
        if (log_q[3][5] !== 1'b1) begin failures++; $display("FAIL bank1_ne got=%b want=1", log_q[3][5]); end
        checks++;
        if (log_q[4][5:1] !== 5'b11010) begin failures++; $display("FAIL bank0_held got=%b want=11010", log_q[4][5:1]); end
    endtask

    task automatic test_branch_flush();
        stim_t s;
        sq = {}; log_q = {};
        sq.push_back(itst(0, 4'hE, 3'd4, 4'b1111));
        sq.push_back(ins(0, 4'hF));
        s = ins(0, 4'hF); s.pcs = 1'b1; sq.push_back(s);
        sq.push_back(idle());
        sq.push_back(itst(1, 4'hE, 3'd2, 4'b0011));
        sq.push_back(itst(0, 4'hE, 3'd4, 4'b1111));
        sq.push_back(ins(0, 4'hF));
        s = itst(0, 4'hE, 3'd2, 4'b0011); s.flush = 1'b1; s.pcs = 1'b1; sq.push_back(s);
        sq.push_back(idle());
        s = idle(); s.bank = 1'b1; sq.push_back(s);
        foreach (sq[i]) begin
            issue(sq[i]); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            log_q.push_back(obs); checks++;
            if (obs !== e) begin failures++; $display("FAIL branch_flush[%0d] got=%b want=%b", i, obs, e); end
        end
        checks++;
        if (log_q[2][8] !== 1'b1) begin failures++; $display("FAIL it_branch_pcsrc got=%b want=1", log_q[2][8]); end
        checks++;
        if (log_q[3][4:1] !== 4'b0000) begin failures++; $display("FAIL it_branch_exit got=%b want=0000", log_q[3][4:1]); end
        checks++;
        if ({log_q[7][8:5], log_q[7][0]} !== 5'b0) begin failures++; $display("FAIL flush_outputs got=%b want=00000", {log_q[7][8:5], log_q[7][0]}); end
        checks++;
        if (log_q[8][4:1] !== 4'b0000) begin failures++; $display("FAIL flush_bank0 got=%b want=0000", log_q[8][4:1]); end
        checks++;
        if (log_q[9][4:1] !== 4'b0000) begin failures++; $display("FAIL flush_bank1 got=%b want=0000", log_q[9][4:1]); end
    endtask

    task automatic test_it_errors();
        sq = {}; log_q = {};
        sq.push_back(itst(0, 4'h0, 3'd0, 4'b0001));
        sq.push_back(idle());
        sq.push_back(itst(0, 4'h0, 3'd5, 4'b0001));
        sq.push_back(itst(0, 4'hE, 3'd3, 4'b0111));
        sq.push_back(ins(0, 4'hF));
        sq.push_back(itst(0, 4'hE, 3'd4, 4'b1111));
        sq.push_back(ins(0, 4'hF));
        sq.push_back(idle());
        foreach (sq[i]) begin
            issue(sq[i]); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            log_q.push_back(obs); checks++;
            if (obs !== e) begin failures++; $display("FAIL it_err[%0d] got=%b want=%b", i, obs, e); end
        end
        checks++;
        if (log_q[0][0] !== 1'b1) begin failures++; $display("FAIL itlen0_err got=%b want=1", log_q[0][0]); end
        checks++;
        if (log_q[1][4] !== 1'b0) begin failures++; $display("FAIL itlen0_idle got=%b want=0", log_q[1][4]); end
        checks++;
        if (log_q[2][0] !== 1'b1) begin failures++; $display("FAIL itlen5_err got=%b want=1", log_q[2][0]); end
        checks++;
        if ({log_q[5][3:1], log_q[5][0]} !== 4'b0101) begin failures++; $display("FAIL it_nested got=%b want=0101", {log_q[5][3:1], log_q[5][0]}); end
        checks++;
        if (log_q[6][3:1] !== 3'd1) begin failures++; $display("FAIL it_nested_consumed got=%0d want=1", log_q[6][3:1]); end
    endtask

    task automatic test_reset_mid();
        sq = {}; log_q = {};
        sq.push_back(itst(0, 4'hE, 3'd4, 4'b0000));
        sq.push_back(ins(0, 4'hE));
        foreach (sq[i]) begin
            issue(sq[i]); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            log_q.push_back(obs); checks++;
            if (obs !== e) begin failures++; $display("FAIL reset_mid[%0d] got=%b want=%b", i, obs, e); end
        end
        do_reset();
        issue(ins(0, 4'hE)); #1;
        e = exp_q.pop_front();
        obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_mid_post got=%b want=%b", obs, e); end
        checks++;
        if (log_q[1][5] !== 1'b0) begin failures++; $display("FAIL reset_mid_else got=%b want=0", log_q[1][5]); end
        checks++;
        if (obs[5:4] !== 2'b10) begin failures++; $display("FAIL reset_mid_own_cond got=%b want=10", obs[5:4]); end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        for (int i = 0; i < 80; i++) begin
            s.valid = ($urandom_range(0, 3) != 0);
            s.flush = ($urandom_range(0, 15) == 0);
            s.bank  = 1'($urandom);
            s.cond  = 4'($urandom);
            s.aluf  = 4'($urandom);
            s.flagw = 2'($urandom);
            s.pcs   = ($urandom_range(0, 4) == 0);
            s.regw  = 1'($urandom);
            s.memw  = 1'($urandom);
            s.its   = ($urandom_range(0, 4) == 0);
            s.itc   = 4'($urandom);
            s.itl   = 3'($urandom_range(0, 5));
            s.itp   = 4'($urandom);
            issue(s); #1;
            e = exp_q.pop_front();
            obs = {PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItRemain, ItErr};
            checks++;
            if (obs !== e) begin failures++; $display("FAIL random[%0d] got=%b want=%b", i, obs, e); end
        end
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        test_reset();
        test_flags();
        test_it_basic();
        test_it_flagwrite();
        test_banks();
        test_branch_flush();
        test_it_errors();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
